// File: rtl/spi_slave_sync.sv
// SPI mode-0 receive slave, oversampled by clk, MSB-first bytes.
// Echoes the previously received byte on miso.
module spi_slave_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       ss,
    input  logic       mosi,
    output logic       miso,
    output logic [7:0] data,
    output logic       valid,
    output logic       sot,
    output logic       eot
);

    logic       sclk_q;
    logic       ss_q;
    logic       first;
    logic [2:0] cnt;
    logic [7:0] sr;
    logic [7:0] tx;
    logic       rise;
    logic       fall;
    logic       ss_rel;
    logic       ss_fell;
    logic [7:0] sr_next;

    assign rise    = sclk & ~sclk_q;
    assign fall    = ~sclk & sclk_q;
    assign ss_rel  = ss & ~ss_q;
    assign ss_fell = ~ss & ss_q;
    assign sr_next = {sr[6:0], mosi};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_q <= 1'b0;
            ss_q   <= 1'b1;
            first  <= 1'b1;
            cnt    <= 3'd0;
            sr     <= 8'h00;
            tx     <= 8'h00;
            data   <= 8'h00;
            valid  <= 1'b0;
            sot    <= 1'b0;
            eot    <= 1'b0;
            miso   <= 1'b0;
        end else begin
            sclk_q <= sclk;
            ss_q   <= ss;
            valid  <= 1'b0;
            sot    <= 1'b0;
            eot    <= ss_rel;
            if (ss) begin
                cnt   <= 3'd0;
                first <= 1'b1;
                miso  <= 1'b0;
            end else begin
                if (rise) begin
                    sr  <= sr_next;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        data  <= sr_next;
                        valid <= 1'b1;
                        sot   <= first;
                        first <= 1'b0;
                        tx    <= sr_next;
                    end
                end
                // preload the MSB as soon as select falls, then advance on fall
                if (fall || ss_fell)
                    miso <= tx[3'd7 - cnt];
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Scoreboard bench for spi_slave_sync: directed bytes, cycle-exact
// valid/sot/eot expectations popped by a negedge monitor.
module tb_spi_slave_sync;

    logic       clk = 1'b0;
    logic       clk_en = 1'b1;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       ss = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] data;
    logic       valid;
    logic       sot;
    logic       eot;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int         c;
        logic [7:0] d;
        logic       s;
    } exp_t;

    exp_t bq[$];
    int   eq[$];

    spi_slave_sync dut (
        .clk   (clk),
        .rst   (rst),
        .sclk  (sclk),
        .ss    (ss),
        .mosi  (mosi),
        .miso  (miso),
        .data  (data),
        .valid (valid),
        .sot   (sot),
        .eot   (eot)
    );

    initial forever begin
        #5;
        if (clk_en) clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (bq.size() == 0) begin
                chk("unexpected_valid", {24'd0, data}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = bq.pop_front();
                chk("valid_cycle", cyc, e.c);
                chk("data", {24'd0, data}, {24'd0, e.d});
                chk("sot", {31'd0, sot}, {31'd0, e.s});
            end
        end else if (sot === 1'b1) begin
            chk("sot_without_valid", 32'd1, 32'd0);
        end
        if (eot === 1'b1) begin
            if (eq.size() == 0)
                chk("unexpected_eot", cyc, 32'hFFFF_FFFF);
            else
                chk("eot_cycle", cyc, eq.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic do_chk,
                            input logic exp_miso, input string nm);
        mosi = b;
        tick(1);
        if (do_chk) chk(nm, {31'd0, miso}, {31'd0, exp_miso});
        sclk = 1'b1;
        tick(2);
        sclk = 1'b0;
        tick(1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_sot,
                             input logic push, input logic do_chk,
                             input logic [7:0] exp_miso);
        for (int i = 7; i >= 0; i--) begin
            mosi = b[i];
            tick(1);
            if (do_chk)
                chk("miso_bit", {31'd0, miso}, {31'd0, exp_miso[i]});
            sclk = 1'b1;
            if (i == 0 && push) bq.push_back('{cyc + 1, b, exp_sot});
            tick(2);
            sclk = 1'b0;
            tick(1);
        end
    endtask

    task automatic select;
        ss = 1'b0;
    endtask

    task automatic release_ss;
        ss = 1'b1;
        eq.push_back(cyc + 1);
        tick(3);
    endtask

    initial begin
        #2 rst = 1'b0;
        #1;
        chk("reset_outputs", {24'd0, data, miso, valid, sot, eot},
            32'd0);
        tick(3);
        rst = 1'b1;
        tick(2);

        // single byte of ones
        select();
        send_byte(8'hFF, 1'b1, 1'b1, 1'b0, 8'h00);
        tick(2);
        release_ss();

        // back-to-back multi-byte
        select();
        for (int k = 0; k < 4; k++)
            send_byte(k[7:0], k == 0, 1'b1, 1'b0, 8'h00);
        release_ss();

        // partial byte is discarded
        select();
        send_bit(1'b1, 1'b0, 1'b0, "");
        send_bit(1'b0, 1'b0, 1'b0, "");
        send_bit(1'b1, 1'b0, 1'b0, "");
        send_bit(1'b0, 1'b0, 1'b0, "");
        send_bit(1'b1, 1'b0, 1'b0, "");
        release_ss();
        chk("data_after_partial", {24'd0, data}, 32'h03);
        select();
        send_byte(8'hA5, 1'b1, 1'b1, 1'b0, 8'h00);
        release_ss();

        // sclk toggling while deselected
        for (int k = 0; k < 16; k++)
            send_bit(k[0], 1'b0, 1'b0, "");
        chk("data_ss_high", {24'd0, data}, 32'hA5);
        chk("miso_ss_high", {31'd0, miso}, 32'd0);

        // miso echo of previous byte
        select();
        send_byte(8'h3C, 1'b1, 1'b1, 1'b0, 8'h00);
        release_ss();
        select();
        send_byte(8'hC3, 1'b1, 1'b1, 1'b1, 8'h3C);
        release_ss();

        // async reset mid-transfer with clk stopped
        select();
        send_bit(1'b1, 1'b1, 1'b1, "miso_msb_c3");
        @(negedge clk);
        #1 clk_en = 1'b0;
        chk("pre_reset_data", {24'd0, data}, 32'hC3);
        chk("pre_reset_miso", {31'd0, miso}, 32'd1);
        rst = 1'b0;
        #1;
        chk("async_reset", {24'd0, data, miso, valid, sot, eot}, 32'd0);
        #10 rst = 1'b1;
        #3 clk_en = 1'b1;
        tick(2);
        send_byte(8'h5A, 1'b1, 1'b1, 1'b1, 8'h00);
        release_ss();

        tick(5);
        chk("byte_queue_empty", bq.size(), 32'd0);
        chk("eot_queue_empty", eq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
